// File: rtl/lpc_io_decode.sv
// lpc_io_decode: LPC I/O-cycle target mapping a 32-byte window onto register-bus strobes
module lpc_io_decode #(
  parameter logic [15:0] BASE_ADDR = 16'h0800
) (
  input  logic       PciReset,
  input  logic       LpcClock,
  input  logic       LFRAME_N,
  input  logic [3:0] LAD_I,
  output logic [3:0] LAD_O,
  output logic       LAD_OE,
  input  logic [7:0] RdData,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWrSW
);
  typedef enum logic [3:0] {
    IDLE, CYCTYPE, ADDR, WDATA_L, WDATA_H, TAR_H1, TAR_H2,
    SYNC, RDATA_L, RDATA_H, TAR_P1, TAR_P2
  } state_t;
  state_t state, nextState;
  logic [1:0] nibCnt;
  logic isWrite;
  logic [15:0] addrSh, addrFull;
  logic addrHit;
  logic [7:0] wrShadow, rdLatch;
  assign addrFull = {addrSh[11:0], LAD_I};
  assign addrHit = addrFull[15:5] == BASE_ADDR[15:5];
  // state register; reset returns to IDLE so LAD_OE drops immediately
  always_ff @(posedge LpcClock or negedge PciReset)
    if (!PciReset) state <= IDLE;
    else state <= nextState;
  // next state from the current field, START/abort overriding everything; outputs decoded from state
  always_comb begin
    nextState = state;
    case (state)
      CYCTYPE: nextState = LAD_I[3:2] == 2'b00 ? ADDR : IDLE;
      ADDR:    nextState = nibCnt != 2'd3 ? ADDR : !addrHit ? IDLE : isWrite ? WDATA_L : TAR_H1;
      WDATA_L: nextState = WDATA_H;
      WDATA_H: nextState = TAR_H1;
      TAR_H1:  nextState = TAR_H2;
      TAR_H2:  nextState = SYNC;
      SYNC:    nextState = isWrite ? TAR_P1 : RDATA_L;
      RDATA_L: nextState = RDATA_H;
      RDATA_H: nextState = TAR_P1;
      TAR_P1:  nextState = TAR_P2;
      default: nextState = IDLE;
    endcase
    if (!LFRAME_N) nextState = LAD_I == 4'h0 ? CYCTYPE : IDLE;
    LAD_OE = state inside {SYNC, RDATA_L, RDATA_H, TAR_P1};
    LAD_O = state == SYNC ? 4'h0 : state == RDATA_L ? rdLatch[3:0] : state == RDATA_H ? rdLatch[7:4] : 4'hF;
    Wr = state == SYNC && isWrite;
  end
  // field capture; writes stay in a shadow until the cycle commits by entering SYNC
  always_ff @(posedge LpcClock or negedge PciReset)
    if (!PciReset) begin
      nibCnt <= 2'd0;
      isWrite <= 1'b0;
      addrSh <= 16'h0;
      Addr <= 8'h00;
      wrShadow <= 8'h00;
      DataWrSW <= 8'h00;
      rdLatch <= 8'h00;
    end else if (LFRAME_N) begin
      if (state == CYCTYPE) begin
        isWrite <= LAD_I[1];
        nibCnt <= 2'd0;
      end
      if (state == ADDR) begin
        addrSh <= addrFull;
        nibCnt <= nibCnt + 2'd1;
        if (nibCnt == 2'd3 && addrHit) Addr <= {3'b000, addrFull[4:0]};
      end
      if (state == WDATA_L) wrShadow[3:0] <= LAD_I;
      if (state == WDATA_H) wrShadow[7:4] <= LAD_I;
      if (state == TAR_H2 && !isWrite) rdLatch <= RdData;
      if (state == TAR_H2 && isWrite) DataWrSW <= wrShadow;
    end
endmodule

// File: tb/tb_lpc_io_decode.sv
// tb_lpc_io_decode: randomized LPC I/O cycles checked by a scoreboard against a period-level model
module tb_lpc_io_decode;
  localparam logic [15:0] BASE = 16'h0800;
  logic PciReset = 1'b0, LpcClock = 1'b0, LFRAME_N = 1'b1;
  logic [3:0] LAD_I = 4'hF, LAD_O;
  logic LAD_OE, Wr;
  logic [7:0] RdData, Addr, DataWrSW;
  logic [7:0] regFile [32];
  typedef struct {
    int kind;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sb [$];
  int errors = 0, checks = 0;
  logic [7:0] lastAddr = 8'h00, lastData = 8'h00;

  lpc_io_decode #(.BASE_ADDR(BASE)) dut (
    .PciReset(PciReset), .LpcClock(LpcClock), .LFRAME_N(LFRAME_N), .LAD_I(LAD_I),
    .LAD_O(LAD_O), .LAD_OE(LAD_OE), .RdData(RdData), .Addr(Addr), .Wr(Wr), .DataWrSW(DataWrSW)
  );

  assign RdData = regFile[Addr[4:0]];
  always #15 LpcClock = ~LpcClock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input logic f, input logic [3:0] l);
    LFRAME_N = f;
    LAD_I = l;
    @(posedge LpcClock);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d);
    exp_t t;
    t.kind = kind;
    t.a = a;
    t.d = d;
    sb.push_back(t);
  endtask

  // One host cycle; periods numbered from the START period (0). kind: 0 write, 1 read, 2 truncated read.
  task automatic runCycle(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d,
                          input int abortP, input int rstP, input bit chain);
    bit w = ct[1];
    bit valid = ct[3:2] == 2'b00 && a[15:5] == BASE[15:5];
    logic [7:0] v = w ? d : regFile[a[4:0]];
    logic [3:0] lad [13];
    int last = chain ? 12 : 13;
    for (int i = 0; i < 13; i++) lad[i] = 4'hF;
    lad[0] = 4'h0;
    lad[1] = ct;
    lad[2] = a[15:12];
    lad[3] = a[11:8];
    lad[4] = a[7:4];
    lad[5] = a[3:0];
    if (w) begin
      lad[6] = d[3:0];
      lad[7] = d[7:4];
    end
    if (valid && abortP > 12 && rstP > 12) push(w ? 0 : 1, {3'b000, a[4:0]}, v);
    if (valid && !w && abortP >= 8 && abortP <= 10 && rstP > 12) push(2, 8'h00, 8'h00);
    for (int p = 0; p < last; p++) begin
      int q = p + 1;
      bit eOe, eWr;
      logic [3:0] eLad;
      if (p == rstP) begin
        PciReset = 1'b0;
        #1;
        chk("reset_async", 32'({LAD_OE, Wr, LAD_O, Addr, DataWrSW}), 32'({2'b00, 4'hF, 16'h0000}));
        lastAddr = 8'h00;
        lastData = 8'h00;
        tick(1'b1, 4'hF);
        PciReset = 1'b1;
        return;
      end
      if (p == abortP) begin
        tick(1'b0, 4'hF);
        chk("abort_release", 32'({LAD_OE, Wr, LAD_O}), 32'({2'b00, 4'hF}));
        return;
      end
      tick(p == 0 ? 1'b0 : 1'b1, lad[p]);
      eOe = valid && (w ? (q == 10 || q == 11) : (q >= 8 && q <= 11));
      eWr = valid && w && q == 10;
      eLad = !eOe ? 4'hF : (q == 11) ? 4'hF : (w || q == 8) ? 4'h0 : q == 9 ? v[3:0] : v[7:4];
      chk($sformatf("period%0d_oe_wr_lad", q), 32'({LAD_OE, Wr, LAD_O}), 32'({eOe, eWr, eLad}));
      if (q == 6) begin
        if (valid) lastAddr = {3'b000, a[4:0]};
        chk("addr_period6", 32'(Addr), 32'(lastAddr));
      end
    end
    if (valid && w) lastData = d;
    chk("datawrsw_hold", 32'(DataWrSW), 32'(lastData));
  endtask

  // monitor: pops the scoreboard whenever the DUT commits a write or presents read data
  initial begin
    int ph = 0;
    logic [3:0] lo = 4'h0;
    exp_t e;
    forever begin
      @(negedge LpcClock);
      if (!PciReset) ph = 0;
      else if (Wr) begin
        if (sb.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("wr_kind", 32'(e.kind), 32'd0);
          chk("wr_addr", 32'(Addr), 32'(e.a));
          chk("wr_data", 32'(DataWrSW), 32'(e.d));
        end
        ph = 3;
      end else if (ph == 3) begin
        chk("tar_p1_drive", 32'({LAD_OE, LAD_O}), 32'h1F);
        ph = 0;
      end else if (LAD_OE) begin
        if (ph == 0) begin
          chk("rd_sync_expected", 32'(sb.size() > 0 && sb[0].kind != 0), 32'd1);
          chk("rd_sync_value", 32'(LAD_O), 32'h0);
          ph = 1;
        end else if (ph == 1) begin
          lo = LAD_O;
          ph = 2;
        end else begin
          if (sb.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("rd_kind", 32'(e.kind), 32'd1);
            chk("rd_addr", 32'(Addr), 32'(e.a));
            chk("rd_data", 32'({LAD_O, lo}), 32'(e.d));
          end
          ph = 3;
        end
      end else if (ph == 1 || ph == 2) begin
        if (sb.size() == 0) chk("unexpected_truncation", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("truncated_kind", 32'(e.kind), 32'd2);
        end
        ph = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regFile[i] = 8'($urandom);
    regFile[31] = 8'h3C;
    #1;
    chk("reset_values", 32'({LAD_OE, Wr, LAD_O, Addr, DataWrSW}), 32'({2'b00, 4'hF, 16'h0000}));
    @(posedge LpcClock);
    @(posedge LpcClock);
    #1;
    PciReset = 1'b1;
    tick(1'b1, 4'hF);
    runCycle(4'h2, 16'h0809, 8'hA5, 99, 99, 1'b0);
    runCycle(4'h0, 16'h081F, 8'h00, 99, 99, 1'b0);
    runCycle(4'h2, 16'h0900, 8'h5A, 99, 99, 1'b0);
    runCycle(4'h4, 16'h0805, 8'h00, 99, 99, 1'b0);
    runCycle(4'h0, 16'h0803, 8'h00, 9, 99, 1'b0);
    tick(1'b1, 4'hF);
    runCycle(4'h0, 16'h0812, 8'h00, 99, 99, 1'b1);
    runCycle(4'h2, 16'h0817, 8'hC3, 99, 99, 1'b0);
    runCycle(4'h0, 16'h081F, 8'h00, 99, 8, 1'b0);
    tick(1'b1, 4'hF);
    for (int n = 0; n < 150; n++) begin
      logic [3:0] ct = $urandom_range(0, 7) < 6 ? {2'b00, 2'($urandom)} : 4'($urandom_range(4, 15));
      logic [15:0] a = $urandom_range(0, 3) != 0 ? {BASE[15:5], 5'($urandom)} : 16'($urandom);
      int abortP = $urandom_range(0, 5) == 0 ? int'($urandom_range(1, 7)) : 99;
      bit chain = abortP == 99 && $urandom_range(0, 1) == 1;
      runCycle(ct, a, 8'($urandom), abortP, 99, chain);
      if (!chain) repeat ($urandom_range(0, 2)) tick(1'b1, 4'hF);
    end
    repeat (4) tick(1'b1, 4'hF);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
